// File: rtl/alu_req_sched_pkg.sv
// rtl/alu_req_sched_pkg.sv - shared types and constants for the ALU request scheduler
package alu_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    WAIT  = ST_WAIT,
    RESP  = ST_RESP
  } state_t;

  typedef struct packed {
    logic err;
    logic oflow;
    logic cout;
    logic g;
    logic l;
    logic e;
  } alu_flags_t;

  localparam logic [3:0] CMD_MUL_INC = 4'd9;
  localparam logic [3:0] CMD_MUL_SHL = 4'd10;

  // Reported when a request carries no valid operands and never reaches the ALU
  localparam alu_flags_t FLAGS_ERR_ONLY = alu_flags_t'(6'b100000);

  // Multiply commands need the longer ALU latency
  function automatic logic is_mul_cmd(input logic mode, input logic [3:0] cmd);
    return mode && ((cmd == CMD_MUL_INC) || (cmd == CMD_MUL_SHL));
  endfunction

endpackage

// File: rtl/alu_req_sched_if.sv
// rtl/alu_req_sched_if.sv - requester, ALU and response signal bundle
interface alu_req_sched_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 2
);

  logic [NUM_REQ-1:0]       REQ_VALID;
  logic [NUM_REQ-1:0]       REQ_READY;
  logic [NUM_REQ*WIDTH-1:0] REQ_OPA;
  logic [NUM_REQ*WIDTH-1:0] REQ_OPB;
  logic [NUM_REQ-1:0]       REQ_CIN;
  logic [NUM_REQ-1:0]       REQ_MODE;
  logic [NUM_REQ*4-1:0]     REQ_CMD;
  logic [NUM_REQ*2-1:0]     REQ_INP_VALID;

  logic [WIDTH-1:0]         ALU_OPA;
  logic [WIDTH-1:0]         ALU_OPB;
  logic                     ALU_CIN;
  logic                     ALU_CE;
  logic                     ALU_MODE;
  logic [3:0]               ALU_CMD;
  logic [1:0]               ALU_INP_VALID;
  logic [2*WIDTH-1:0]       ALU_RES;
  logic                     ALU_ERR;
  logic                     ALU_OFLOW;
  logic                     ALU_COUT;
  logic                     ALU_G;
  logic                     ALU_L;
  logic                     ALU_E;

  logic [NUM_REQ-1:0]       RSP_VALID;
  logic [2*WIDTH-1:0]       RSP_RES;
  logic [5:0]               RSP_FLAGS;

  // Scheduler side
  modport master (
    input  REQ_VALID, REQ_OPA, REQ_OPB, REQ_CIN, REQ_MODE, REQ_CMD, REQ_INP_VALID,
    output REQ_READY,
    output ALU_OPA, ALU_OPB, ALU_CIN, ALU_CE, ALU_MODE, ALU_CMD, ALU_INP_VALID,
    input  ALU_RES, ALU_ERR, ALU_OFLOW, ALU_COUT, ALU_G, ALU_L, ALU_E,
    output RSP_VALID, RSP_RES, RSP_FLAGS
  );

  // Requesters plus ALU side
  modport slave (
    output REQ_VALID, REQ_OPA, REQ_OPB, REQ_CIN, REQ_MODE, REQ_CMD, REQ_INP_VALID,
    input  REQ_READY,
    input  ALU_OPA, ALU_OPB, ALU_CIN, ALU_CE, ALU_MODE, ALU_CMD, ALU_INP_VALID,
    output ALU_RES, ALU_ERR, ALU_OFLOW, ALU_COUT, ALU_G, ALU_L, ALU_E,
    input  RSP_VALID, RSP_RES, RSP_FLAGS
  );

endinterface

// File: rtl/alu_req_sched_rr_arbiter.sv
// rtl/alu_req_sched_rr_arbiter.sv - combinational round-robin one-hot grant
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0]   gnt_idx_o
);

  logic [PTR_W-1:0] idx;
  logic             found;

  // First requester at or above the pointer wins, wrapping modulo NUM_REQ
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = PTR_W'((int'(ptr_i) + off) % NUM_REQ);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/alu_req_sched.sv
// rtl/alu_req_sched.sv - round-robin sharing of one ALU between several requesters
module alu_req_sched
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int NUM_REQ  = 2,
  parameter int LAT_BASE = 1,
  parameter int LAT_MUL  = 2
) (
  input logic           CLK,
  input logic           RST,
  alu_req_sched_if.master bus
);

  localparam int         PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] LAT_B = 8'(LAT_BASE);
  localparam logic [7:0] LAT_M = 8'(LAT_MUL);

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_q, rr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic               cin_q, cin_d, mode_q, mode_d;
  logic [3:0]         cmd_q, cmd_d;
  logic [1:0]         iv_q, iv_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  alu_flags_t         flags_q, flags_d;

  logic [NUM_REQ-1:0] gnt;
  logic [PTR_W-1:0]   gnt_idx;
  logic [WIDTH-1:0]   sel_opa, sel_opb;
  logic               sel_cin, sel_mode;
  logic [3:0]         sel_cmd;
  logic [1:0]         sel_iv;
  alu_flags_t         alu_flags;
  logic               ce;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .req_i     (bus.REQ_VALID),
    .ptr_i     (rr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign alu_flags = alu_flags_t'({bus.ALU_ERR, bus.ALU_OFLOW, bus.ALU_COUT,
                                   bus.ALU_G, bus.ALU_L, bus.ALU_E});

  // Pick the granted requester's fields out of the packed request buses
  always_comb begin
    sel_opa  = '0;
    sel_opb  = '0;
    sel_cin  = 1'b0;
    sel_mode = 1'b0;
    sel_cmd  = '0;
    sel_iv   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_opa  = bus.REQ_OPA[i*WIDTH +: WIDTH];
        sel_opb  = bus.REQ_OPB[i*WIDTH +: WIDTH];
        sel_cin  = bus.REQ_CIN[i];
        sel_mode = bus.REQ_MODE[i];
        sel_cmd  = bus.REQ_CMD[i*4 +: 4];
        sel_iv   = bus.REQ_INP_VALID[i*2 +: 2];
      end
    end
  end

  // Accept, issue, wait out the ALU latency, then return the captured result
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    cin_d   = cin_q;
    mode_d  = mode_q;
    cmd_d   = cmd_q;
    iv_d    = iv_q;
    res_d   = res_q;
    flags_d = flags_q;
    case (state_q)
      IDLE: begin
        if (|bus.REQ_VALID) begin
          owner_d = gnt_idx;
          opa_d   = sel_opa;
          opb_d   = sel_opb;
          cin_d   = sel_cin;
          mode_d  = sel_mode;
          cmd_d   = sel_cmd;
          iv_d    = sel_iv;
          rr_d    = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (iv_q == 2'b00) begin
          res_d   = '0;
          flags_d = FLAGS_ERR_ONLY;
          state_d = RESP;
        end else begin
          cnt_d   = is_mul_cmd(mode_q, cmd_q) ? LAT_M : LAT_B;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          res_d   = bus.ALU_RES;
          flags_d = alu_flags;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset aborts any operation in flight
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      cin_q   <= 1'b0;
      mode_q  <= 1'b0;
      cmd_q   <= '0;
      iv_q    <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      cin_q   <= cin_d;
      mode_q  <= mode_d;
      cmd_q   <= cmd_d;
      iv_q    <= iv_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  // CE is held through ISSUE and WAIT unless the operands were flagged invalid
  assign ce = ((state_q == ISSUE) && (iv_q != 2'b00)) || (state_q == WAIT);

  assign bus.ALU_CE        = ce;
  assign bus.ALU_OPA       = opa_q;
  assign bus.ALU_OPB       = opb_q;
  assign bus.ALU_CIN       = cin_q;
  assign bus.ALU_MODE      = mode_q;
  assign bus.ALU_CMD       = cmd_q;
  assign bus.ALU_INP_VALID = ce ? iv_q : 2'b00;

  assign bus.REQ_READY = (state_q == IDLE) ? gnt : '0;
  assign bus.RSP_VALID = (state_q == RESP) ? (NUM_REQ'(1) << owner_q) : '0;
  assign bus.RSP_RES   = res_q;
  assign bus.RSP_FLAGS = flags_q;

endmodule
